// File: rtl/ibus_if_pkg.sv
// Shared definitions for the instruction-fetch bus interface.
package ibus_if_pkg;

  localparam int          REG_BUS     = 32;
  localparam logic        CHIP_ENABLE = 1'b1;
  localparam logic        RST_ENABLE  = 1'b1;
  localparam logic [31:0] NOP         = 32'h0000_0000;
  localparam logic [3:0]  SEL_ALL     = 4'hF;
  localparam logic [3:0]  SEL_NONE    = 4'h0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } ibus_state_t;

endpackage

// File: rtl/ibus_if.sv
// Instruction fetch port: turns PC fetch requests into single Wishbone reads,
// buffers the word while the pipeline is stalled, aborts hung bus cycles.
module ibus_if
  import ibus_if_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_BUS-1:0] pc_i,
  input  logic               ce_i,
  input  logic [5:0]         stall_i,
  input  logic               flush_i,
  output logic [REG_BUS-1:0] inst_o,
  output logic               stallreq_o,
  output logic               err_o,
  output logic [REG_BUS-1:0] wb_adr_o,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic               wb_we_o,
  output logic [3:0]         wb_sel_o,
  input  logic [REG_BUS-1:0] wb_dat_i,
  input  logic               wb_ack_i
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  // Abort on the BUSY cycle that brings the count up to TIMEOUT_CYC, so the
  // bus cycle lasts exactly TIMEOUT_CYC clocks without an acknowledge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ibus_state_t        state;
  logic [REG_BUS-1:0] rd_buf;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               cyc_q;

  // Strobe and cycle always move together for single reads.
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = 1'b0;

  // Fetch state machine with registered bus outputs and error pulse.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state    <= S_IDLE;
      cyc_q    <= 1'b0;
      wb_sel_o <= SEL_NONE;
      wb_adr_o <= '0;
      rd_buf   <= '0;
      tmo_cnt  <= '0;
      err_o    <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ce_i == CHIP_ENABLE && !flush_i) begin
            wb_adr_o <= pc_i;
            cyc_q    <= 1'b1;
            wb_sel_o <= SEL_ALL;
            tmo_cnt  <= '0;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (flush_i) begin
            // Flush beats a coincident ack: the fetched word is dropped.
            cyc_q    <= 1'b0;
            wb_sel_o <= SEL_NONE;
            state    <= S_IDLE;
          end else if (wb_ack_i) begin
            cyc_q    <= 1'b0;
            wb_sel_o <= SEL_NONE;
            rd_buf   <= wb_dat_i;
            state    <= (|stall_i) ? S_HOLD : S_IDLE;
          end else if (tmo_cnt == CNT_LAST) begin
            cyc_q    <= 1'b0;
            wb_sel_o <= SEL_NONE;
            tmo_cnt  <= tmo_cnt + CNT_ONE;
            err_o    <= 1'b1;
            state    <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_ONE;
          end
        end
        S_HOLD: begin
          if (flush_i || !(|stall_i)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Instruction and stall request are combinational so a zero-wait ack
  // delivers the word and releases the pipeline in the same cycle.
  always_comb begin
    stallreq_o = 1'b0;
    inst_o     = NOP;
    case (state)
      S_IDLE: stallreq_o = ce_i & ~flush_i;
      S_BUSY: begin
        stallreq_o = ~wb_ack_i & ~flush_i;
        if (wb_ack_i && !flush_i) inst_o = wb_dat_i;
      end
      S_HOLD: inst_o = rd_buf;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ibus_if.sv
// Bench for ibus_if: per-cycle vector table, hand sequences for timeout and
// reset-mid-cycle, and a scoreboarded random fetch stream against a bus slave.
module tb_ibus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic [31:0] inst_o;
  logic        stallreq_o;
  logic        err_o;
  logic [31:0] wb_adr_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  int n_tests = 0;
  int n_fail  = 0;

  ibus_if #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .stall_i(stall_i),
    .flush_i(flush_i), .inst_o(inst_o), .stallreq_o(stallreq_o), .err_o(err_o),
    .wb_adr_o(wb_adr_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ce;
    logic [31:0] pc;
    logic [5:0]  stall;
    logic        flush;
    logic        ack;
    logic [31:0] dat;
    logic [31:0] e_inst;
    logic        e_sreq;
    logic        e_cyc;
    logic        chk_adr;
    logic [31:0] e_adr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic ce, logic [31:0] pc, logic [5:0] stall,
                              logic flush, logic ack, logic [31:0] dat,
                              logic [31:0] e_inst, logic e_sreq, logic e_cyc,
                              logic chk_adr, logic [31:0] e_adr);
    vec_t v;
    v.ce = ce; v.pc = pc; v.stall = stall; v.flush = flush; v.ack = ack;
    v.dat = dat; v.e_inst = e_inst; v.e_sreq = e_sreq; v.e_cyc = e_cyc;
    v.chk_adr = chk_adr; v.e_adr = e_adr;
    return v;
  endfunction

  // Slave read data derived from the address so a wrong address shows up.
  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ce_i = 1'b0; pc_i = '0; stall_i = '0; flush_i = 1'b0;
    wb_ack_i = 1'b0; wb_dat_i = '0;
  endtask

  logic [31:0] sb[$];
  logic [31:0] exp_w;

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick(); tick();

    // Reset state
    chk("rst cyc", {31'b0, wb_cyc_o}, 32'd0);
    chk("rst stb", {31'b0, wb_stb_o}, 32'd0);
    chk("rst sel", {28'b0, wb_sel_o}, 32'd0);
    chk("rst adr", wb_adr_o, 32'd0);
    chk("rst err", {31'b0, err_o}, 32'd0);
    chk("rst inst", inst_o, 32'd0);
    chk("rst sreq", {31'b0, stallreq_o}, 32'd0);
    rst = 1'b0;

    // ce pc stall flush ack dat | inst sreq cyc chk_adr adr
    vt.push_back(mk(1, 32'h04, 6'd0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 32'h0));
    vt.push_back(mk(1, 32'h04, 6'd0, 0, 0, 32'h0,        32'h0,        1, 1, 1, 32'h04));
    vt.push_back(mk(1, 32'h04, 6'd0, 0, 1, 32'h3C010001, 32'h3C010001, 0, 1, 1, 32'h04));
    vt.push_back(mk(0, 32'h04, 6'd0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 32'h0));
    vt.push_back(mk(1, 32'h08, 6'd0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 32'h0));
    vt.push_back(mk(1, 32'h08, 6'd3, 0, 1, 32'h24210002, 32'h24210002, 0, 1, 1, 32'h08));
    vt.push_back(mk(1, 32'h0C, 6'd3, 0, 0, 32'h0,        32'h24210002, 0, 0, 0, 32'h0));
    vt.push_back(mk(1, 32'h0C, 6'd3, 0, 0, 32'h0,        32'h24210002, 0, 0, 0, 32'h0));
    vt.push_back(mk(0, 32'h0C, 6'd0, 0, 0, 32'h0,        32'h24210002, 0, 0, 0, 32'h0));
    vt.push_back(mk(0, 32'h0C, 6'd0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 32'h0));
    vt.push_back(mk(1, 32'h10, 6'd0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 32'h0));
    vt.push_back(mk(1, 32'h10, 6'd0, 1, 1, 32'hDEADBEEF, 32'h0,        0, 1, 1, 32'h10));
    vt.push_back(mk(1, 32'h20, 6'd0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 32'h0));
    vt.push_back(mk(1, 32'h20, 6'd0, 0, 0, 32'h0,        32'h0,        1, 1, 1, 32'h20));
    vt.push_back(mk(0, 32'h20, 6'd0, 0, 1, 32'h00000123, 32'h00000123, 0, 1, 1, 32'h20));
    vt.push_back(mk(0, 32'h20, 6'd0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 32'h0));
    vt.push_back(mk(1, 32'h24, 6'd0, 1, 0, 32'h0,        32'h0,        0, 0, 0, 32'h0));
    vt.push_back(mk(0, 32'h24, 6'd0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 32'h0));
    vt.push_back(mk(1, 32'h30, 6'd0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 32'h0));
    vt.push_back(mk(0, 32'h30, 6'd1, 0, 1, 32'h00000055, 32'h00000055, 0, 1, 1, 32'h30));
    vt.push_back(mk(0, 32'h30, 6'd1, 1, 0, 32'h0,        32'h00000055, 0, 0, 0, 32'h0));
    vt.push_back(mk(0, 32'h30, 6'd1, 0, 0, 32'h0,        32'h0,        0, 0, 0, 32'h0));

    foreach (vt[i]) begin
      ce_i = vt[i].ce; pc_i = vt[i].pc; stall_i = vt[i].stall;
      flush_i = vt[i].flush; wb_ack_i = vt[i].ack; wb_dat_i = vt[i].dat;
      #1;
      chk($sformatf("row%0d inst", i), inst_o, vt[i].e_inst);
      chk($sformatf("row%0d sreq", i), {31'b0, stallreq_o}, {31'b0, vt[i].e_sreq});
      chk($sformatf("row%0d cyc", i), {31'b0, wb_cyc_o}, {31'b0, vt[i].e_cyc});
      chk($sformatf("row%0d stb", i), {31'b0, wb_stb_o}, {31'b0, vt[i].e_cyc});
      chk($sformatf("row%0d sel", i), {28'b0, wb_sel_o}, vt[i].e_cyc ? 32'hF : 32'h0);
      chk($sformatf("row%0d we", i), {31'b0, wb_we_o}, 32'd0);
      chk($sformatf("row%0d err", i), {31'b0, err_o}, 32'd0);
      if (vt[i].chk_adr) chk($sformatf("row%0d adr", i), wb_adr_o, vt[i].e_adr);
      tick();
    end

    // ce low for 10 cycles while the bus acks spuriously
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      wb_ack_i = i[0];
      wb_dat_i = $urandom;
      #1;
      chk("noce cyc", {31'b0, wb_cyc_o}, 32'd0);
      chk("noce stb", {31'b0, wb_stb_o}, 32'd0);
      chk("noce sreq", {31'b0, stallreq_o}, 32'd0);
      chk("noce inst", inst_o, 32'd0);
      tick();
    end

    // Timeout: 8 BUSY cycles without ack, then one-cycle err pulse
    idle_inputs();
    ce_i = 1'b1; pc_i = 32'h40;
    tick();
    ce_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("tmo busy%0d cyc", i), {31'b0, wb_cyc_o}, 32'd1);
      chk($sformatf("tmo busy%0d err", i), {31'b0, err_o}, 32'd0);
      chk($sformatf("tmo busy%0d inst", i), inst_o, 32'd0);
      tick();
    end
    chk("tmo abort cyc", {31'b0, wb_cyc_o}, 32'd0);
    chk("tmo abort sel", {28'b0, wb_sel_o}, 32'd0);
    chk("tmo abort err", {31'b0, err_o}, 32'd1);
    chk("tmo abort inst", inst_o, 32'd0);
    tick();
    chk("tmo after err", {31'b0, err_o}, 32'd0);

    // Reset in the middle of a bus cycle, then a late ack
    ce_i = 1'b1; pc_i = 32'h50;
    tick();
    chk("rstbusy cyc", {31'b0, wb_cyc_o}, 32'd1);
    rst = 1'b1;
    wb_ack_i = 1'b0;
    tick();
    rst = 1'b0; ce_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'hCAFEF00D;
    #1;
    chk("rstbusy cyc0", {31'b0, wb_cyc_o}, 32'd0);
    chk("rstbusy sel", {28'b0, wb_sel_o}, 32'd0);
    chk("rstbusy adr", wb_adr_o, 32'd0);
    chk("rstbusy err", {31'b0, err_o}, 32'd0);
    chk("rstbusy inst", inst_o, 32'd0);
    chk("rstbusy sreq", {31'b0, stallreq_o}, 32'd0);
    tick();
    wb_ack_i = 1'b0;
    #1;
    chk("rstbusy late cyc", {31'b0, wb_cyc_o}, 32'd0);
    chk("rstbusy late inst", inst_o, 32'd0);
    tick();

    // Random fetch stream with variable slave latency; pc wanders during BUSY
    idle_inputs();
    for (int n = 0; n < 20; n++) begin
      int lat;
      ce_i = 1'b1; pc_i = $urandom & 32'hFFFF_FFFC; wb_ack_i = 1'b0;
      #1;
      chk("sb req sreq", {31'b0, stallreq_o}, 32'd1);
      chk("sb req idle", {31'b0, wb_cyc_o}, 32'd0);
      sb.push_back(mem_word(pc_i));
      tick();
      lat = $urandom_range(0, 3);
      for (int k = 0; k < lat; k++) begin
        pc_i = $urandom;
        #1;
        chk("sb wait cyc", {31'b0, wb_cyc_o}, 32'd1);
        chk("sb wait sreq", {31'b0, stallreq_o}, 32'd1);
        chk("sb wait inst", inst_o, 32'd0);
        tick();
      end
      wb_ack_i = 1'b1;
      wb_dat_i = wb_cyc_o ? mem_word(wb_adr_o) : 32'hBAD0_BAD0;
      #1;
      if (sb.size() == 0) begin
        chk("sb underflow", 32'd1, 32'd0);
      end else begin
        exp_w = sb.pop_front();
        chk($sformatf("sb fetch%0d inst", n), inst_o, exp_w);
      end
      chk("sb ack sreq", {31'b0, stallreq_o}, 32'd0);
      tick();
      wb_ack_i = 1'b0;
    end
    chk("sb drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ibus_if.md
IBUS_IF -- requirements
Module: ibus_if

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 255, max cycles BUSY waits for wb_ack_i before abort.
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset rst, synchronous, active-high; clock clk.
REQ-004 pc_i  in  32  fetch address from PC register.
REQ-005 ce_i  in  1  fetch request from PC register; 1 = fetch enabled.
REQ-006 stall_i  in  6  pipeline stall vector from CTRL; any bit set = pipeline stalled.
REQ-007 flush_i  in  1  exception flush from CTRL; abandon current fetch.
REQ-008 inst_o  out  32  instruction to IF/ID; 32'h00000000 (NOP) when not valid.
REQ-009 stallreq_o  out  1  stall request to CTRL while fetch outstanding.
REQ-010 err_o  out  1  one-cycle pulse on bus timeout.
REQ-011 wb_adr_o  out  32  Wishbone address.
REQ-012 wb_cyc_o / wb_stb_o  out  1 each  Wishbone cycle / strobe.
REQ-013 wb_we_o  out  1  always 0; read-only port.
REQ-014 wb_sel_o  out  4  byte select; 4'hF during a read, else 4'h0.
REQ-015 wb_dat_i  in  32  Wishbone read data.
REQ-016 wb_ack_i  in  1  Wishbone acknowledge.

Function
REQ-017 FSM states: IDLE, BUSY, HOLD; registered.
REQ-018 IDLE: when ce_i=1 and flush_i=0, next cycle drive wb_adr_o=pc_i, cyc=stb=1, sel=4'hF, clear timeout counter, go BUSY; else stay IDLE.
REQ-019 BUSY, wb_ack_i=1, flush_i=0: drop cyc/stb/sel next cycle, latch wb_dat_i into rd_buf; go HOLD if stall_i!=0, else IDLE.
REQ-020 BUSY, flush_i=1 (with or without ack): drop cyc/stb/sel next cycle, discard data, go IDLE; flush wins over ack.
REQ-021 BUSY, no ack, no flush: timeout counter increments; when counter reaches TIMEOUT_CYC, drop cyc/stb, pulse err_o one cycle, go IDLE.
REQ-022 HOLD: remain while stall_i!=0; go IDLE when stall_i==0; flush_i=1 forces IDLE.
REQ-023 stallreq_o combinational: IDLE -> ce_i & ~flush_i; BUSY -> ~wb_ack_i & ~flush_i; HOLD -> 0.
REQ-024 inst_o combinational: BUSY with wb_ack_i=1 -> wb_dat_i; HOLD -> rd_buf; all other cases -> 32'h00000000.
REQ-025 Zero-wait acknowledge: one fetch costs 2 cycles minimum (IDLE request, BUSY ack); inst_o valid in the ack cycle.
REQ-026 wb_adr_o held stable for entire BUSY; pc_i changes during BUSY ignored.
REQ-027 wb_ack_i outside BUSY ignored; no state or output change.
REQ-028 Timeout counter width = clog2(TIMEOUT_CYC+1); no wrap-around before abort.

Reset
REQ-029 rst=1 at posedge: state IDLE, cyc=stb=0, sel=4'h0, wb_adr_o=0, rd_buf=0, counter=0, err_o=0.
REQ-030 rst mid-BUSY terminates bus cycle same edge; late ack after reset ignored per REQ-027.
REQ-031 rst has priority over flush_i, stall_i and wb_ack_i.

Structure
REQ-032 State encodings, NOP constant, ChipEnable/RstEnable, RegBus width belong in shared defines.
REQ-033 Single flat module; no sub-module.

Verification
REQ-034 ce_i=1, pc_i=32'h00000004, ack one cycle after stb with wb_dat_i=32'h3C010001 -> wb_adr_o=32'h4, inst_o=32'h3C010001 in ack cycle, stallreq_o falls same cycle, state IDLE.
REQ-035 Ack with stall_i=6'b000011 for 3 cycles, wb_dat_i=32'h24210002 -> HOLD, inst_o=32'h24210002 every HOLD cycle, stallreq_o=0, IDLE after stall clears.
REQ-036 flush_i=1 in BUSY same cycle as ack, data 32'hDEADBEEF -> inst_o=0, cyc/stb=0 next cycle, new fetch at new pc_i=32'h00000020 follows.
REQ-037 No ack, TIMEOUT_CYC=8 -> cyc/stb dropped after 8 BUSY cycles, err_o high exactly one cycle, inst_o=0.
REQ-038 rst=1 during BUSY, then ack arrives -> all outputs at reset values, ack ignored, inst_o=0.
REQ-039 ce_i=0 for 10 cycles with wb_ack_i toggling -> cyc/stb stay 0, stallreq_o=0, inst_o=0.
